// File: rtl/rom_map_pkg.sv
// rom_map_pkg: ROM region map, region indices and download FSM state type.
package rom_map_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} dl_state_t;
    localparam int N_REGIONS = 12;
    localparam int RGN_MAIN0  = 0;
    localparam int RGN_MAIN1  = 1;
    localparam int RGN_MAIN2  = 2;
    localparam int RGN_SUB0   = 3;
    localparam int RGN_SUB1   = 4;
    localparam int RGN_SUB2   = 5;
    localparam int RGN_SOUND0 = 6;
    localparam int RGN_SOUND1 = 7;
    localparam int RGN_SOUND2 = 8;
    localparam int RGN_PROM0  = 9;
    localparam int RGN_PROM1  = 10;
    localparam int RGN_PROM2  = 11;
    localparam logic [24:0] REGION_BASE [N_REGIONS] = '{
        25'h00000, 25'h04000, 25'h08000,
        25'h10000, 25'h14000, 25'h18000,
        25'h20000, 25'h24000, 25'h28000,
        25'h2C000, 25'h2C100, 25'h2C200
    };
    localparam logic [24:0] REGION_SIZE [N_REGIONS] = '{
        25'h04000, 25'h04000, 25'h04000,
        25'h04000, 25'h04000, 25'h04000,
        25'h04000, 25'h04000, 25'h04000,
        25'h00100, 25'h00100, 25'h00100
    };
    // One extra bit keeps base+size from wrapping at the top of the address space.
    function automatic logic region_hit(input logic [24:0] addr, input int idx);
        logic [25:0] lo, hi;
        lo = {1'b0, REGION_BASE[idx]};
        hi = lo + {1'b0, REGION_SIZE[idx]};
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction
endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: byte address to one-hot region select, lowest index wins.
module rom_region_decode
    import rom_map_pkg::*;
#(
    parameter int NREG = N_REGIONS
) (
    input  logic [24:0]     i_addr,
    output logic [NREG-1:0] o_cs
);
    always_comb begin
        o_cs = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (region_hit(i_addr, i)) begin
                o_cs    = '0;
                o_cs[i] = 1'b1;
            end
    end
endmodule

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: routes ioctl ROM download bytes to EPROM ports and holds CPUs in reset.
module rom_dl_sequencer
    import rom_map_pkg::*;
#(
    parameter int          NREG        = N_REGIONS,
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [15:0] HOLD_CYCLES = 16'd256,
    parameter logic [24:0] EXP_BYTES   = 25'h2C000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ioctl_download,
    input  logic [7:0]      ioctl_index,
    input  logic            ioctl_wr,
    input  logic [24:0]     ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    output logic            dl_wr,
    output logic [19:0]     dl_addr,
    output logic [7:0]      dl_data,
    output logic [NREG-1:0] dl_cs,
    output logic            cpu_reset,
    output logic            load_done,
    output logic            err_unmapped,
    output logic            short_load,
    output logic [24:0]     byte_cnt,
    output logic [15:0]     checksum
);
    dl_state_t       r_state, w_state_nxt;
    logic            r_dl_prev;
    logic [15:0]     r_hold_cnt;
    logic            r_dl_wr;
    logic [19:0]     r_dl_addr;
    logic [7:0]      r_dl_data;
    logic [NREG-1:0] r_dl_cs;
    logic            r_err;
    logic            r_short;
    logic [24:0]     r_byte_cnt;
    logic [15:0]     r_checksum;
    logic [NREG-1:0] w_cs;
    logic            w_start, w_acc, w_hit, w_fall, w_enter;
    logic [24:0]     w_cnt_nxt;

    rom_region_decode #(.NREG(NREG)) u_decode (
        .i_addr (ioctl_addr),
        .o_cs   (w_cs)
    );

    assign w_start   = ioctl_download & ~r_dl_prev & (ioctl_index == ROM_INDEX);
    assign w_acc     = (r_state == LOAD) & ioctl_wr;
    assign w_hit     = w_acc & (|w_cs);
    assign w_fall    = (r_state == LOAD) & ~ioctl_download;
    assign w_enter   = (w_state_nxt == LOAD) & (r_state != LOAD);
    assign w_cnt_nxt = r_byte_cnt + {24'd0, w_hit};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_start ? LOAD : IDLE;
            LOAD:    w_state_nxt = ioctl_download ? LOAD : HOLD;
            HOLD:    w_state_nxt = (r_hold_cnt == '0) ? RUN : HOLD;
            RUN:     w_state_nxt = w_start ? LOAD : RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Edge history resets high so a download already active at reset exit cannot start a load.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dl_prev  <= 1'b1;
            r_hold_cnt <= '0;
            r_dl_wr    <= 1'b0;
            r_dl_addr  <= '0;
            r_dl_data  <= '0;
            r_dl_cs    <= '0;
            r_err      <= 1'b0;
            r_short    <= 1'b0;
            r_byte_cnt <= '0;
            r_checksum <= '0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_dl_wr   <= w_hit;
            r_dl_cs   <= w_hit ? w_cs : '0;
            if (w_acc) begin
                r_dl_addr <= ioctl_addr[19:0];
                r_dl_data <= ioctl_dout;
            end
            if (w_enter) begin
                r_err      <= 1'b0;
                r_short    <= 1'b0;
                r_byte_cnt <= '0;
                r_checksum <= '0;
            end else if (w_hit) begin
                r_byte_cnt <= w_cnt_nxt;
                r_checksum <= r_checksum + {8'd0, ioctl_dout};
            end else if (w_acc) begin
                r_err <= 1'b1;
            end
            if (w_fall) begin
                r_hold_cnt <= HOLD_CYCLES - 16'd1;
                r_short    <= w_cnt_nxt < EXP_BYTES;
            end else if (r_state == HOLD && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - 16'd1;
            end
        end
    end

    assign dl_wr        = r_dl_wr;
    assign dl_addr      = r_dl_addr;
    assign dl_data      = r_dl_data;
    assign dl_cs        = r_dl_cs;
    assign cpu_reset    = r_state != RUN;
    assign load_done    = r_state == RUN;
    assign err_unmapped = r_err;
    assign short_load   = r_short;
    assign byte_cnt     = r_byte_cnt;
    assign checksum     = r_checksum;
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: randomized download stimulus with a queue scoreboard and region-map model.
module tb_rom_dl_sequencer;
    localparam logic [15:0] HOLD = 16'd4;
    localparam logic [24:0] EXP  = 25'd64;
    localparam int RB [12] = '{'h00000, 'h04000, 'h08000, 'h10000, 'h14000, 'h18000,
                               'h20000, 'h24000, 'h28000, 'h2C000, 'h2C100, 'h2C200};
    localparam int RS [12] = '{'h4000, 'h4000, 'h4000, 'h4000, 'h4000, 'h4000,
                               'h4000, 'h4000, 'h4000, 'h100, 'h100, 'h100};

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        dl_wr, cpu_reset, load_done, err_unmapped, short_load;
    logic [19:0] dl_addr;
    logic [7:0]  dl_data;
    logic [11:0] dl_cs;
    logic [24:0] byte_cnt;
    logic [15:0] checksum;

    typedef struct packed {
        logic [19:0] a;
        logic [7:0]  d;
        logic [11:0] cs;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_cnt = 0;
    int   m_sum = 0;
    bit   m_err = 0;
    bit   m_load = 0;

    always #5 CLK = ~CLK;

    rom_dl_sequencer #(.ROM_INDEX(8'd0), .HOLD_CYCLES(HOLD), .EXP_BYTES(EXP)) dut (
        .CLK(CLK), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_cs(dl_cs),
        .cpu_reset(cpu_reset), .load_done(load_done), .err_unmapped(err_unmapped),
        .short_load(short_load), .byte_cnt(byte_cnt), .checksum(checksum)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int ref_region(input logic [24:0] a);
        for (int i = 0; i < 12; i++)
            if (int'(a) >= RB[i] && int'(a) < RB[i] + RS[i]) return i;
        return -1;
    endfunction

    function automatic logic [24:0] rand_mapped();
        int r, s;
        r = $urandom_range(0, 11);
        s = $urandom_range(0, 3);
        return 25'(s == 0 ? RB[r] : s == 1 ? RB[r] + RS[r] - 1 : RB[r] + $urandom_range(0, RS[r] - 1));
    endfunction

    function automatic logic [24:0] rand_any();
        int r, s;
        r = $urandom_range(0, 11);
        s = $urandom_range(0, 5);
        return s == 0 ? 25'(RB[r] + RS[r]) : s == 1 ? 25'($urandom_range(0, 'h1FFFFFF)) :
               s == 2 ? 25'('h0C000 + $urandom_range(0, 'h3FFF)) : rand_mapped();
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input bit fall);
        logic [7:0] d;
        int r;
        d = 8'($urandom);
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (fall) ioctl_download = 1'b0;
        if (m_load) begin
            r = ref_region(a);
            if (r >= 0) begin
                exp_q.push_back({a[19:0], d, 12'(12'd1 << r)});
                m_cnt++;
                m_sum = (m_sum + int'(d)) % 65536;
            end else m_err = 1;
        end
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_load();
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        step();
        m_load = 1;
        m_cnt = 0;
        m_sum = 0;
        m_err = 0;
    endtask

    task automatic load_body(input int n, input bit mapped_only);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            wr_byte(mapped_only ? rand_mapped() : rand_any(), 0);
        end
    endtask

    task automatic finish_load(input bit fall_write);
        if (fall_write) wr_byte(rand_mapped(), 1);
        else begin
            ioctl_download = 1'b0;
            step();
        end
        m_load = 0;
        chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
        chk("checksum", 32'(checksum), 32'(m_sum));
        chk("err_unmapped", 32'(err_unmapped), 32'(m_err));
        chk("short_load", 32'(short_load), 32'(m_cnt < int'(EXP)));
        for (int k = 1; k < int'(HOLD); k++) begin
            if (k == 2) begin
                ioctl_wr = 1'b1;
                ioctl_addr = rand_mapped();
            end
            step();
            ioctl_wr = 1'b0;
            chk("cpu_reset during hold", 32'(cpu_reset), 1);
        end
        step();
        chk("cpu_reset after hold", 32'(cpu_reset), 0);
        chk("load_done after hold", 32'(load_done), 1);
        chk("scoreboard drained", 32'(exp_q.size()), 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (dl_wr) begin
            chk("dl_wr expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dl_addr", 32'(dl_addr), 32'(e.a));
                chk("dl_data", 32'(dl_data), 32'(e.d));
                chk("dl_cs", 32'(dl_cs), 32'(e.cs));
            end
        end else chk("dl_cs idle", 32'(dl_cs), 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        ioctl_download = 1'b1;
        repeat (3) step();
        chk("reset cpu_reset", 32'(cpu_reset), 1);
        chk("reset load_done", 32'(load_done), 0);
        chk("reset byte_cnt", 32'(byte_cnt), 0);
        chk("reset checksum", 32'(checksum), 0);
        chk("reset err_unmapped", 32'(err_unmapped), 0);
        chk("reset short_load", 32'(short_load), 0);
        chk("reset dl_addr", 32'(dl_addr), 0);
        RESET = 1'b0;
        step();
        repeat (3) wr_byte(rand_mapped(), 0);
        chk("level download ignored cnt", 32'(byte_cnt), 0);
        chk("level download ignored rst", 32'(cpu_reset), 1);
        ioctl_download = 1'b0;
        step();
        start_load();
        load_body(800, 0);
        finish_load(0);
        start_load();
        load_body(int'(EXP) - 1, 1);
        finish_load(1);
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        step();
        repeat (4) wr_byte(rand_mapped(), 0);
        ioctl_download = 1'b0;
        step();
        chk("other index load_done", 32'(load_done), 1);
        chk("other index cpu_reset", 32'(cpu_reset), 0);
        chk("other index byte_cnt", 32'(byte_cnt), 32'(m_cnt));
        start_load();
        chk("reload cpu_reset", 32'(cpu_reset), 1);
        chk("reload load_done", 32'(load_done), 0);
        chk("reload byte_cnt", 32'(byte_cnt), 0);
        chk("reload checksum", 32'(checksum), 0);
        chk("reload short_load", 32'(short_load), 0);
        load_body(int'(EXP) - 2, 1);
        finish_load(1);
        start_load();
        load_body(10, 0);
        repeat (2) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        m_load = 0;
        step();
        chk("mid-load reset cpu_reset", 32'(cpu_reset), 1);
        chk("mid-load reset byte_cnt", 32'(byte_cnt), 0);
        chk("mid-load reset err", 32'(err_unmapped), 0);
        repeat (3) wr_byte(rand_mapped(), 0);
        chk("no resume after reset", 32'(byte_cnt), 0);
        ioctl_download = 1'b0;
        step();
        start_load();
        load_body(20, 0);
        finish_load(1);
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
